// File: rtl/multicycle_fsm_if.sv
// Memory handshake between the multicycle control FSM and the unified memory.
// The FSM drives the request side; the memory answers with mem_ready.
interface multicycle_fsm_if;
    logic mem_req;
    logic MemWrite;
    logic AdrSrc;
    logic mem_ready;

    modport master (
        output mem_req,
        output MemWrite,
        output AdrSrc,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemWrite,
        input  AdrSrc,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_fsm.sv
// Control FSM for a multicycle RV32I-subset core with a unified, stallable memory.
// Moore-style sequencing; datapath controls are decoded from state plus instruction fields.
module multicycle_fsm (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     Zero,
    input  logic                     N,
    input  logic                     V,
    input  logic                     C,
    multicycle_fsm_if.master         mem,
    output logic                     IRWrite,
    output logic                     PCWrite,
    output logic                     RegWrite,
    output logic [1:0]               ALUSrcA,
    output logic [1:0]               ALUSrcB,
    output logic [1:0]               ResultSrc,
    output logic [2:0]               ImmSrc,
    output logic [3:0]               ALUControl,
    output logic                     retire,
    output logic                     illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    state_t     state_reg;
    state_t     state_next;

    logic       mem_req_dec;
    logic       mem_write_dec;
    logic       ir_write_dec;
    logic       pc_write_dec;
    logic       reg_write_dec;
    logic       retire_dec;
    logic       branch_taken;
    logic [3:0] alu_op_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Shared funct3 decode for register and immediate ALU ops; SUB exists only for R-type.
    always_comb begin
        alu_op_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_op_dec = (state_reg == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_dec = ALU_SLL;
            3'b010:  alu_op_dec = ALU_SLT;
            3'b011:  alu_op_dec = ALU_SLTU;
            3'b100:  alu_op_dec = ALU_XOR;
            3'b101:  alu_op_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_dec = ALU_OR;
            default: alu_op_dec = ALU_AND;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = Zero;
            3'b001:  branch_taken = !Zero;
            3'b100:  branch_taken = N ^ V;
            3'b101:  branch_taken = !(N ^ V);
            3'b110:  branch_taken = !C;
            3'b111:  branch_taken = C;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        mem_req_dec   = 1'b0;
        mem_write_dec = 1'b0;
        mem.AdrSrc    = 1'b0;
        ir_write_dec  = 1'b0;
        pc_write_dec  = 1'b0;
        reg_write_dec = 1'b0;
        retire_dec    = 1'b0;
        illegal       = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ImmSrc        = IMM_I;
        ALUControl    = ALU_ADD;

        case (state_reg)
            S_FETCH: begin
                mem_req_dec  = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_dec = mem.mem_ready;
                pc_write_dec = mem.mem_ready;
                if (mem.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = (op == OP_LOAD) ? IMM_I : IMM_S;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem.AdrSrc  = 1'b1;
                mem_req_dec = 1'b1;
                if (mem.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_dec = 1'b1;
                retire_dec    = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem.AdrSrc    = 1'b1;
                mem_req_dec   = 1'b1;
                mem_write_dec = 1'b1;
                retire_dec    = mem.mem_ready;
                if (mem.mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_op_dec;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_op_dec;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_dec = 1'b1;
                retire_dec    = 1'b1;
                state_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                // funct3 010/011 are not branch encodings; treat as an illegal instruction.
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    state_next = S_ILLEGAL;
                end else begin
                    pc_write_dec = branch_taken;
                    retire_dec   = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_dec = 1'b1;
                state_next   = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = S_JAL;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Reset is asynchronous, so enables are also masked combinationally while it is held.
    assign mem.mem_req  = mem_req_dec   & reset;
    assign mem.MemWrite = mem_write_dec & reset;
    assign IRWrite      = ir_write_dec  & reset;
    assign PCWrite      = pc_write_dec  & reset;
    assign RegWrite     = reg_write_dec & reset;
    assign retire       = retire_dec    & reset;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Randomized bench for multicycle_fsm: per-instruction latency, write-enable and
// decode expectations derived from the instruction-class table, plus reset/illegal cases.
module tb_multicycle_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, N, V, C;
    logic       IRWrite, PCWrite, RegWrite, retire, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

    multicycle_fsm_if mem ();

    always #5 clk = ~clk;

    multicycle_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .N          (N),
        .V          (V),
        .C          (C),
        .mem        (mem.master),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .retire     (retire),
        .illegal    (illegal)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ALU operation by mnemonic: add/sub, sll, slt, sltu, xor, srl/sra, or, and.
    function automatic int alu_ref(input logic [2:0] f3, input logic f7, input logic rtype);
        case (f3)
            3'd0:    return (rtype && f7) ? 1 : 0;
            3'd1:    return 7;
            3'd2:    return 5;
            3'd3:    return 6;
            3'd4:    return 4;
            3'd5:    return f7 ? 9 : 8;
            3'd6:    return 3;
            default: return 2;
        endcase
    endfunction

    // beq, bne, blt, bge, bltu, bgeu expressed through the ALU flags of A-B.
    function automatic logic taken_ref(input logic [2:0] f3, input logic z, input logic n,
                                       input logic v, input logic c);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return n != v;
            3'd5:    return n == v;
            3'd6:    return !c;
            default: return c;
        endcase
    endfunction

    // Drive one memory cycle: stall each phase for the requested number of cycles.
    task automatic drive_ready(input int fw, input int mw, inout int fwc, inout int mwc);
        if (mem.mem_req && !mem.AdrSrc) begin
            if (fwc < fw) begin mem.mem_ready = 1'b0; fwc++; end
            else mem.mem_ready = 1'b1;
        end else if (mem.mem_req) begin
            if (mwc < mw) begin mem.mem_ready = 1'b0; mwc++; end
            else mem.mem_ready = 1'b1;
        end else begin
            mem.mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Called just after a rising edge with the FSM sitting in FETCH.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [3:0] flags, input int fw, input int mw);
        int lat = 0, rw_exp = 0, pc_extra = 0, alu_exp = -1;
        bit is_mem = 0, is_store = 0;
        int cyc = 0, fwc = 0, mwc = 0;
        int irw = 0, pcw = 0, rww = 0, rw_early = 0, mwr = 0, dreq = 0;
        bit done = 0, ill = 0;
        logic [3:0] alu_seen = '0;
        logic [2:0] imm_dec = '0, imm3 = '0;
        logic [1:0] srca3 = '0;

        op = o; funct3 = f3; funct7b5 = f7;
        {Zero, N, V, C} = flags;

        case (o)
            7'b0110011: begin lat = 4; rw_exp = 1; alu_exp = alu_ref(f3, f7, 1'b1); end
            7'b0010011: begin lat = 4; rw_exp = 1; alu_exp = alu_ref(f3, f7, 1'b0); end
            7'b0110111, 7'b0010111: begin lat = 4; rw_exp = 1; end
            7'b0000011: begin lat = 5; rw_exp = 1; is_mem = 1; end
            7'b0100011: begin lat = 4; is_mem = 1; is_store = 1; end
            7'b1100011: begin lat = 3; pc_extra = int'(taken_ref(f3, flags[3], flags[2], flags[1], flags[0])); end
            7'b1101111: begin lat = 4; rw_exp = 1; pc_extra = 1; end
            default:    begin lat = 5; rw_exp = 1; pc_extra = 1; end
        endcase
        lat += fw + (is_mem ? mw : 0);

        while (!done && !ill && cyc < 40) begin
            @(negedge clk);
            drive_ready(fw, mw, fwc, mwc);
            #1;
            cyc++;
            irw += int'(IRWrite);
            pcw += int'(PCWrite);
            mwr += int'(mem.MemWrite);
            dreq += int'(mem.mem_req && mem.AdrSrc);
            if (cyc == fw + 2) imm_dec = ImmSrc;
            if (cyc == fw + 3) begin alu_seen = ALUControl; srca3 = ALUSrcA; imm3 = ImmSrc; end
            if (retire) begin
                done = 1;
                rww += int'(RegWrite);
            end else begin
                rw_early += int'(RegWrite);
            end
            ill = illegal;
        end
        @(posedge clk);
        #1;

        $display("instr op=%b f3=%b f7=%b flags=%b fw=%0d mw=%0d cycles=%0d expected=%0d",
                 o, f3, f7, flags, fw, mw, cyc, lat);
        check_value("retired", 32'(done), 32'd1);
        check_value("no_illegal", 32'(ill), 32'd0);
        check_value("latency", cyc, lat);
        check_value("irwrite_count", irw, 1);
        check_value("pcwrite_count", pcw, 1 + pc_extra);
        check_value("regwrite_at_retire", rww, rw_exp);
        check_value("regwrite_early", rw_early, 0);
        check_value("memwrite_cycles", mwr, is_store ? mw + 1 : 0);
        check_value("data_req_cycles", dreq, is_mem ? mw + 1 : 0);
        check_value("decode_immsrc", imm_dec, (o == 7'b1101111) ? 3 : 2);
        if (alu_exp >= 0) check_value("alu_control", alu_seen, alu_exp);
        if (o == 7'b1100111) begin
            check_value("jalr_srca", srca3, 2);
            check_value("jalr_immsrc", imm3, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_value("rst_mem_req", mem.mem_req, 0);
        check_value("rst_enables", {mem.MemWrite, IRWrite, PCWrite, RegWrite, retire}, 0);
        check_value("rst_illegal", illegal, 0);
        @(negedge clk);
        mem.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_value("first_fetch_req", mem.mem_req, 1);
        check_value("first_fetch_adr", mem.AdrSrc, 0);
        @(posedge clk);
        #1;
        $display("reset sequence done");
    endtask

    // Run an instruction expected to land in ILLEGAL at cycle exp_cyc, then hold there.
    task automatic run_illegal(input logic [6:0] o, input logic [2:0] f3, input int exp_cyc);
        int cyc = 0, first = 0, activity = 0;
        op = o; funct3 = f3; funct7b5 = 1'b0;
        {Zero, N, V, C} = 4'b0;
        while (first == 0 && cyc < 12) begin
            @(negedge clk);
            mem.mem_ready = 1'b1;
            #1;
            cyc++;
            activity += int'(retire) + int'(RegWrite) + ((cyc > 1) ? int'(PCWrite) : 0);
            if (illegal) first = cyc;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem.mem_ready = 1'($urandom_range(0, 1));
            #1;
            activity += int'(retire) + int'(RegWrite) + int'(PCWrite) + int'(IRWrite) +
                        int'(mem.mem_req) + int'(mem.MemWrite);
        end
        $display("illegal op=%b f3=%b entered_at=%0d expected=%0d", o, f3, first, exp_cyc);
        check_value("illegal_entry_cycle", first, exp_cyc);
        check_value("illegal_sticky", illegal, 1);
        check_value("illegal_no_activity", activity, 0);
        do_reset();
    endtask

    task automatic reset_during_store();
        int seen = 0, cyc = 0;
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            if (mem.mem_req && !mem.AdrSrc) mem.mem_ready = 1'b1;
            else if (mem.mem_req) mem.mem_ready = 1'b0;
            else mem.mem_ready = 1'b1;
            #1;
            cyc++;
            if (mem.MemWrite) seen++;
        end
        check_value("store_held", seen, 2);
        reset = 1'b0;
        #1;
        $display("reset asserted during store, MemWrite=%0d mem_req=%0d", mem.MemWrite, mem.mem_req);
        check_value("store_reset_memwrite", mem.MemWrite, 0);
        check_value("store_reset_req", mem.mem_req, 0);
        @(negedge clk);
        mem.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check_value("post_reset_req", mem.mem_req, 1);
        check_value("post_reset_adr", mem.AdrSrc, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] kinds [9];
        logic [2:0] br_f3 [6];
        logic [6:0] o;
        logic [2:0] f3;

        kinds = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                  7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        reset = 1'b0;
        op = '0; funct3 = '0; funct7b5 = 1'b0;
        {Zero, N, V, C} = 4'b0;
        mem.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Directed scenarios.
        run_instr(7'b0110011, 3'b000, 1'b0, 4'b0000, 0, 0);   // add
        run_instr(7'b0110011, 3'b000, 1'b1, 4'b0000, 0, 0);   // sub
        run_instr(7'b0000011, 3'b010, 1'b0, 4'b0000, 0, 3);   // lw, 3 stall cycles
        run_instr(7'b1100011, 3'b100, 1'b0, 4'b0100, 0, 0);   // blt taken (N=1,V=0)
        run_instr(7'b1100011, 3'b100, 1'b0, 4'b0110, 0, 0);   // blt not taken (N=1,V=1)
        run_instr(7'b1100111, 3'b000, 1'b0, 4'b0000, 0, 0);   // jalr
        run_instr(7'b0100011, 3'b010, 1'b0, 4'b0000, 1, 2);   // sw with stalls
        run_instr(7'b0010011, 3'b101, 1'b1, 4'b0000, 0, 0);   // srai

        run_illegal(7'b1111111, 3'b000, 3);
        run_illegal(7'b1100011, 3'b010, 4);

        reset_during_store();
        run_instr(7'b0110011, 3'b111, 1'b0, 4'b0000, 0, 0);

        for (int n = 0; n < 40; n++) begin
            o = kinds[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            if (o == 7'b1100011) f3 = br_f3[$urandom_range(0, 5)];
            run_instr(o, f3, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-003 op / funct3 / funct7b5  input  7/3/1  fields of the instruction register, Instr[6:0], Instr[14:12], Instr[30].
REQ-004 Zero, N, V, C  input  1 each  ALU flags of current ALU operation (C=1 means no borrow on subtract).
REQ-005 mem_ready  input  1  unified memory completes the request presented this cycle.
REQ-006 mem_req / MemWrite  output  1/1  memory request; MemWrite qualifies mem_req as a store.
REQ-007 AdrSrc  output  1  memory address select: 0 PC, 1 Result.
REQ-008 IRWrite, PCWrite, RegWrite  output  1 each  register enables.
REQ-009 ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 (A), 11 zero.
REQ-010 ALUSrcB  output  2  00 rs2 (WriteData), 01 ImmExt, 10 constant 4.
REQ-011 ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-012 ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
REQ-014 retire  output  1  one-cycle pulse in the final state of each instruction.
REQ-015 illegal  output  1  sticky flag: unsupported op or branch funct3 decoded.

Function
REQ-016 Moore FSM; outputs are decoded from the current state plus op/funct3/funct7b5/flags; outputs not listed for a state are 0.
REQ-017 FETCH: AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, add, ImmSrc=J if op=1101111 else B; next state by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, other ILLEGAL.
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=I (load) / S (store); next MEMREAD (load) or MEMWRITE (store).
REQ-020 MEMREAD: AdrSrc=1, ResultSrc=00, mem_req=1; hold until mem_ready, then MEMWB.
REQ-021 MEMWB: ResultSrc=01, RegWrite=1, retire=1; next FETCH.
REQ-022 MEMWRITE: AdrSrc=1, ResultSrc=00, mem_req=1, MemWrite=1; hold until mem_ready; on mem_ready retire=1, next FETCH.
REQ-023 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I; both next ALUWB.
REQ-024 ALU decode (EXECR/EXECI) by funct3: 000 add (sub only EXECR with funct7b5=1), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl / sra when funct7b5=1, 110 or, 111 and.
REQ-025 ALUWB: ResultSrc=00, RegWrite=1, retire=1; next FETCH.
REQ-026 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, retire=1; PCWrite = taken: funct3 000 Zero, 001 !Zero, 100 N^V, 101 !(N^V), 110 !C, 111 C; next FETCH; funct3 010/011 go to ILLEGAL with PCWrite=0, retire=0.
REQ-027 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB (rd = OldPC+4).
REQ-028 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add; next JAL (target LSB clearing is the datapath's responsibility).
REQ-029 LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=U, add; AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=U, add; both next ALUWB.
REQ-030 ILLEGAL: illegal=1, all enables 0, no exit except reset.
REQ-031 mem_ready is ignored in states that do not assert mem_req.
REQ-032 Latency (mem_ready immediate): R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch 3, jal 4, jalr 5.

Reset
REQ-033 reset=0 forces state FETCH and illegal=0 asynchronously; while reset=0, mem_req, MemWrite, IRWrite, PCWrite, RegWrite, retire are 0.
REQ-034 First FETCH request is presented in the first cycle after reset deasserts; reset mid-instruction abandons the instruction with no further write enables.

Verification
REQ-035 add (op 0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH, DECODE, EXECR (ALUControl 0000), ALUWB with RegWrite=1 and retire=1; total 4 cycles.
REQ-036 lw with mem_ready low 3 cycles in MEMREAD -> mem_req held with AdrSrc=1, no RegWrite until MEMWB; 8 cycles total.
REQ-037 blt (f3 100) with N=1,V=0 -> PCWrite=1 in BRANCH; with N=1,V=1 -> PCWrite=0; both retire after 3 cycles.
REQ-038 jalr -> DECODE, JALR (ALUSrcA=10, ImmSrc=000), JAL (PCWrite=1), ALUWB (RegWrite=1); op 1111111 -> illegal=1 held until reset.
REQ-039 reset driven low during MEMWRITE with mem_ready=0 -> MemWrite drops to 0 immediately; after release, FETCH with mem_req=1, AdrSrc=0.
